preprocess_lanes: RTL

Parametrised pre-processing stage placed between instruction fetch and the CORDIC iteration core. It accepts instruction packets `{tag, opcode, z, lane[LANES-1:0]}` over a valid/ready handshake. Each lane operand is conditioned in a 2-stage pipeline: ±OFFSET with signed saturation for the square-root opcode, pass-through otherwise. All lanes complete together and land in an output FIFO, so the core sees one joined packet per instruction, with tag and opcode aligned.

---
 rtl/preprocess_lanes.sv | 139 +++++++++++++
 1 files changed

// File: rtl/preprocess_lanes.sv
// Lane pre-conditioning between fetch and the CORDIC core: a 2-stage lane pipe
// (square-root offset with saturation) feeding a credit-controlled FWFT output FIFO.
module preprocess_lanes #(
  parameter int unsigned        DATA_W     = 32,
  parameter int unsigned        LANES      = 2,
  parameter int unsigned        TAG_W      = 8,
  parameter int unsigned        OP_W       = 4,
  parameter logic [OP_W-1:0]    OP_SQRT    = OP_W'(4'b1000),
  parameter logic [DATA_W-1:0]  OFFSET     = DATA_W'(32'h2000_0000),
  parameter int unsigned        FIFO_DEPTH = 4,
  localparam int unsigned       PW         = TAG_W + OP_W + DATA_W * (LANES + 1),
  localparam int unsigned       CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PW-1:0]    in_packet,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PW-1:0]    out_packet,
  output logic [LANES-1:0] out_sat,
  output logic [CNT_W-1:0] fifo_count
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned LANE_W = DATA_W * LANES;
  localparam int unsigned OP_LSB = DATA_W * (LANES + 1);

  logic              accept_en_q, accept_en_d;
  logic              s1_valid_q, s1_valid_d;
  logic              s1_sqrt_q, s1_sqrt_d;
  logic [PW-1:0]     s1_pkt_q, s1_pkt_d;
  logic              s2_valid_q, s2_valid_d;
  logic [PW-1:0]     s2_pkt_q, s2_pkt_d;
  logic [LANES-1:0]  s2_sat_q, s2_sat_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]     mem_q [FIFO_DEPTH];
  logic [LANES-1:0]  sat_mem_q [FIFO_DEPTH];

  logic              accept;
  logic              push;
  logic              pop;
  logic [CNT_W:0]    credit_used;
  logic [LANE_W-1:0] lane_res;
  logic [LANES-1:0]  lane_sat;

  // Credits cover queued entries plus everything still in the pipe, so the FIFO cannot overflow.
  assign credit_used = (CNT_W+1)'(cnt_q) + (CNT_W+1)'(s1_valid_q) + (CNT_W+1)'(s2_valid_q);
  assign in_ready    = accept_en_q && (credit_used < (CNT_W+1)'(FIFO_DEPTH));
  assign accept      = in_valid && in_ready;
  assign push        = s2_valid_q;
  assign out_valid   = (cnt_q != '0);
  assign pop         = out_valid && out_ready;
  assign out_packet  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_sat     = out_valid ? sat_mem_q[rd_ptr_q] : '0;
  assign fifo_count  = cnt_q;

  // Per-lane offset and saturation, one sign-extended bit of headroom.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    localparam bit IS_EVEN = ((g % 2) == 0);
    logic [DATA_W:0]   a_ext;
    logic [DATA_W:0]   off_ext;
    logic [DATA_W:0]   sum;
    logic              sat;
    logic [DATA_W-1:0] res;

    assign a_ext   = {s1_pkt_q[DATA_W*g + DATA_W - 1], s1_pkt_q[DATA_W*g +: DATA_W]};
    assign off_ext = {OFFSET[DATA_W-1], OFFSET};
    assign sum     = !s1_sqrt_q ? a_ext : (IS_EVEN ? (a_ext + off_ext) : (a_ext - off_ext));
    assign sat     = sum[DATA_W] ^ sum[DATA_W-1];
    assign res     = !sat ? sum[DATA_W-1:0]
                   : (sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}});

    assign lane_res[DATA_W*g +: DATA_W] = res;
    assign lane_sat[g]                  = sat;
  end

  always_comb begin
    accept_en_d = 1'b1;
    s1_valid_d  = accept;
    s1_pkt_d    = s1_pkt_q;
    s1_sqrt_d   = s1_sqrt_q;
    if (accept) begin
      s1_pkt_d  = in_packet;
      s1_sqrt_d = (in_packet[OP_LSB +: OP_W] == OP_SQRT);
    end

    s2_valid_d = s1_valid_q;
    s2_pkt_d   = {s1_pkt_q[PW-1:LANE_W], lane_res};
    s2_sat_d   = lane_sat;

    wr_ptr_d = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      accept_en_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_sqrt_q   <= 1'b0;
      s1_pkt_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_pkt_q    <= '0;
      s2_sat_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
    end else begin
      accept_en_q <= accept_en_d;
      s1_valid_q  <= s1_valid_d;
      s1_sqrt_q   <= s1_sqrt_d;
      s1_pkt_q    <= s1_pkt_d;
      s2_valid_q  <= s2_valid_d;
      s2_pkt_q    <= s2_pkt_d;
      s2_sat_q    <= s2_sat_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the count is zero.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q]     <= s2_pkt_q;
      sat_mem_q[wr_ptr_q] <= s2_sat_q;
    end
  end

endmodule
